// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: field widths, opcodes,
// accumulator source encodings, sequencer states and the control strobe bundle.
package bip_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 5;
  localparam int ADDR_W   = 11;
  localparam int CYCLES_W = 32;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'd7;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op_sub;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_control_unit_if.sv
// Bus between the BIP sequencer, its program memory and the accumulator
// datapath / data memory control inputs.
interface bip_control_unit_if #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 11
);
    // Timing contract: insmem_enable is high for one cycle (FETCH) with
    // insmem_addr valid; instruction must be valid the following cycle (EXEC).
    // operand and every strobe are valid in EXEC only and are captured by the
    // datapath on the clock edge that ends EXEC; they read 0 in all other cycles.
    logic [NB_DATA-1:0] instruction;
    logic [NB_ADDR-1:0] insmem_addr;
    logic               insmem_enable;
    logic [NB_ADDR-1:0] operand;
    logic [1:0]         sel_a;
    logic               sel_b;
    logic               op_sub;
    logic               wr_acc;
    logic               wr_ram;
    logic               rd_ram;

    modport master (
        input  instruction,
        output insmem_addr, insmem_enable, operand,
        output sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram
    );

    modport slave (
        output instruction,
        input  insmem_addr, insmem_enable, operand,
        input  sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram
    );
endinterface

// File: rtl/bip_instruction_decoder.sv
// Combinational opcode decode into the one-cycle datapath/data-memory strobes.
// Outputs are forced to 0 unless i_enable is high (the EXEC cycle).
module bip_instruction_decoder
    import bip_pkg::*;
(
    input  logic                i_enable,
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_t               o_ctrl,
    output logic                o_is_hlt
);

    always_comb begin
        o_ctrl   = '0;
        o_is_hlt = 1'b0;
        if (i_enable) begin
            case (i_opcode)
                OP_HLT: o_is_hlt = 1'b1;
                OP_STO: o_ctrl.wr_ram = 1'b1;
                OP_LD: begin
                    o_ctrl.rd_ram = 1'b1;
                    o_ctrl.sel_a  = SEL_A_RAM;
                    o_ctrl.wr_acc = 1'b1;
                end
                OP_LDI: begin
                    o_ctrl.sel_a  = SEL_A_IMM;
                    o_ctrl.wr_acc = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    o_ctrl.rd_ram = 1'b1;
                    o_ctrl.sel_a  = SEL_A_ALU;
                    o_ctrl.sel_b  = 1'b0;
                    o_ctrl.op_sub = (i_opcode == OP_SUB);
                    o_ctrl.wr_acc = 1'b1;
                end
                OP_ADDI, OP_SUBI: begin
                    o_ctrl.sel_a  = SEL_A_ALU;
                    o_ctrl.sel_b  = 1'b1;
                    o_ctrl.op_sub = (i_opcode == OP_SUBI);
                    o_ctrl.wr_acc = 1'b1;
                end
                // Opcodes 8..31 are NOPs: no strobes, PC still advances.
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: program counter, FETCH/EXEC/WAIT/HALT control,
// run/step execution and a saturating active-cycle counter for the debug unit.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int NB_DATA            = INSTR_W,
    parameter int NB_OPCODE          = OPCODE_W,
    parameter int LOG2_N_INSMEM_ADDR = ADDR_W,
    parameter int NB_CYCLES          = CYCLES_W
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    bip_control_unit_if.master   bus,
    output logic                 o_halt,
    output logic [NB_CYCLES-1:0] o_cycles,
    output state_t               o_state
);

    state_t                          state;
    logic [LOG2_N_INSMEM_ADDR-1:0]   pc;
    logic [NB_CYCLES-1:0]            cycles;
    logic                            in_exec;
    logic                            is_hlt;
    ctrl_t                           ctrl;
    logic [NB_OPCODE-1:0]            opcode;

    assign in_exec = (state == ST_EXEC);
    assign opcode  = bus.instruction[NB_DATA-1 -: NB_OPCODE];

    bip_instruction_decoder u_decoder (
        .i_enable (in_exec),
        .i_opcode (opcode),
        .o_ctrl   (ctrl),
        .o_is_hlt (is_hlt)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state  <= ST_IDLE;
            pc     <= '0;
            cycles <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (i_start) begin
                        state  <= ST_FETCH;
                        pc     <= '0;
                        cycles <= '0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                    if (~&cycles) cycles <= cycles + 1'b1;
                end
                ST_EXEC: begin
                    if (~&cycles) cycles <= cycles + 1'b1;
                    if (is_hlt) begin
                        state <= ST_HALT;
                    end else begin
                        // 11-bit PC wraps naturally from the last address to 0.
                        pc    <= pc + 1'b1;
                        state <= i_step_mode ? ST_WAIT : ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (~&cycles) cycles <= cycles + 1'b1;
                    if (i_step || !i_step_mode) state <= ST_FETCH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state so an asynchronous reset clears them at once.
    assign bus.insmem_addr   = pc;
    assign bus.insmem_enable = (state == ST_FETCH);
    assign bus.operand       = in_exec ? bus.instruction[LOG2_N_INSMEM_ADDR-1:0] : '0;
    assign bus.sel_a         = ctrl.sel_a;
    assign bus.sel_b         = ctrl.sel_b;
    assign bus.op_sub        = ctrl.op_sub;
    assign bus.wr_acc        = ctrl.wr_acc;
    assign bus.wr_ram        = ctrl.wr_ram;
    assign bus.rd_ram        = ctrl.rd_ram;

    assign o_halt   = (state == ST_HALT);
    assign o_cycles = cycles;
    assign o_state  = state;

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: behavioural 1-cycle program memory,
// per-EXEC scoreboard of expected {pc, operand, strobes}, scenario tasks.
module tb_bip_control_unit;
  import bip_pkg::*;

  localparam int W = 29;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        halt;
  logic [31:0] cycles;
  state_t      dut_state;

  always #5 clk = ~clk;

  bip_control_unit_if #(.NB_DATA(16), .NB_ADDR(11)) bus ();

  bip_control_unit dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_start     (start),
    .i_step_mode (step_mode),
    .i_step      (step),
    .bus         (bus),
    .o_halt      (halt),
    .o_cycles    (cycles),
    .o_state     (dut_state)
  );

  logic [15:0] mem [0:2047];

  always @(posedge clk) begin
    if (bus.insmem_enable) bus.instruction <= mem[bus.insmem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           exec_seen = 0;
  bit           sb_en = 1'b0;
  logic [W-1:0] obs;
  logic [W-1:0] exp_v;

  function automatic logic [W-1:0] exp_ctrl(input logic [10:0] pc, input logic [15:0] ins);
    logic [1:0] sa;
    logic       sb, sub, wa, wr, rd;
    sa = 2'd0; sb = 1'b0; sub = 1'b0; wa = 1'b0; wr = 1'b0; rd = 1'b0;
    case (ins[15:11])
      5'd1: wr = 1'b1;
      5'd2: begin rd = 1'b1; sa = 2'd0; wa = 1'b1; end
      5'd3: begin sa = 2'd1; wa = 1'b1; end
      5'd4: begin rd = 1'b1; sa = 2'd2; wa = 1'b1; end
      5'd5: begin sa = 2'd2; sb = 1'b1; wa = 1'b1; end
      5'd6: begin rd = 1'b1; sa = 2'd2; sub = 1'b1; wa = 1'b1; end
      5'd7: begin sa = 2'd2; sb = 1'b1; sub = 1'b1; wa = 1'b1; end
      default: ;
    endcase
    return {pc, ins[10:0], sa, sb, sub, wa, wr, rd};
  endfunction

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] arg);
    return {op, arg};
  endfunction

  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      obs = {bus.insmem_addr, bus.operand, bus.sel_a, bus.sel_b, bus.op_sub,
             bus.wr_acc, bus.wr_ram, bus.rd_ram};
      checks++;
      if (dut_state == ST_EXEC) begin
        exec_seen++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_exec: got %h required no EXEC", obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin
            failures++;
            $display("FAIL sb_exec: got %h required %h", obs, exp_v);
          end
        end
      end else if (obs[17:0] !== 18'd0) begin
        failures++;
        $display("FAIL sb_quiet_outside_exec: got %h required 0 (state %0d)", obs[17:0], dut_state);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_standard();
    mem[0] = mk(5'd2, 11'd1);
    mem[1] = mk(5'd5, 11'd2);
    mem[2] = mk(5'd1, 11'd7);
    mem[3] = mk(5'd3, 11'd8);
    mem[4] = mk(5'd6, 11'd2);
    mem[5] = mk(5'd4, 11'd2);
    mem[6] = mk(5'd1, 11'd11);
    mem[7] = mk(5'd3, 11'd3);
    mem[8] = mk(5'd7, 11'd3);
    mem[9] = mk(5'd0, 11'd0);
  endtask

  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_ctrl(11'(i), mem[i]));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dut_state == s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_state !== ST_IDLE || halt !== 1'b0 || cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d halt=%b cycles=%0d required 0/0/0", dut_state, halt, cycles);
    end
    checks++;
    if (bus.insmem_addr !== 11'd0 || bus.insmem_enable !== 1'b0 || bus.operand !== 11'd0 ||
        {bus.sel_a, bus.sel_b, bus.op_sub, bus.wr_acc, bus.wr_ram, bus.rd_ram} !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%h en=%b operand=%h required all 0",
               bus.insmem_addr, bus.insmem_enable, bus.operand);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_release_idle: got state=%0d required %0d", dut_state, ST_IDLE);
    end
  endtask

  task automatic test_run_program();
    bit ok;
    int base;
    load_standard();
    push_expected(10);
    base = exec_seen;
    sb_en = 1'b1;
    pulse_start();
    checks++;
    if (dut_state !== ST_FETCH || bus.insmem_enable !== 1'b1 || bus.insmem_addr !== 11'd0) begin
      failures++;
      $display("FAIL run_first_fetch: got state=%0d en=%b addr=%0d required FETCH/1/0",
               dut_state, bus.insmem_enable, bus.insmem_addr);
    end
    @(negedge clk);
    checks++;
    if (dut_state !== ST_EXEC) begin
      failures++;
      $display("FAIL run_first_exec: got state=%0d required %0d", dut_state, ST_EXEC);
    end
    wait_state(ST_HALT, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL run_halt_timeout: got no HALT required HALT"); end
    checks++;
    if (halt !== 1'b1 || bus.insmem_addr !== 11'd9 || cycles !== 32'd20) begin
      failures++;
      $display("FAIL run_halt_status: got halt=%b pc=%0d cycles=%0d required 1/9/20",
               halt, bus.insmem_addr, cycles);
    end
    checks++;
    if (exp_q.size() != 0 || exec_seen - base != 10) begin
      failures++;
      $display("FAIL run_exec_count: got left=%0d execs=%0d required 0/10", exp_q.size(), exec_seen - base);
    end
  endtask

  task automatic test_step_mode();
    bit ok;
    int base;
    step_mode = 1'b1;
    push_expected(10);
    base = exec_seen;
    pulse_start();
    wait_state(ST_WAIT, 10, ok);
    checks++;
    if (!ok || cycles !== 32'd2 || exec_seen - base != 1) begin
      failures++;
      $display("FAIL step_first_wait: got ok=%b cycles=%0d execs=%0d required 1/2/1", ok, cycles, exec_seen - base);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (dut_state !== ST_WAIT || cycles !== 32'd7 || exec_seen - base != 1) begin
      failures++;
      $display("FAIL step_hold_wait: got state=%0d cycles=%0d execs=%0d required WAIT/7/1",
               dut_state, cycles, exec_seen - base);
    end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if (dut_state !== ST_WAIT || bus.insmem_addr !== 11'd1 || cycles !== 32'd8) begin
      failures++;
      $display("FAIL step_start_ignored: got state=%0d pc=%0d cycles=%0d required WAIT/1/8",
               dut_state, bus.insmem_addr, cycles);
    end
    start = 1'b1; step = 1'b1;
    @(negedge clk) begin start = 1'b0; step = 1'b0; end
    checks++;
    if (dut_state !== ST_FETCH || bus.insmem_addr !== 11'd1 || cycles !== 32'd9) begin
      failures++;
      $display("FAIL step_wins_over_start: got state=%0d pc=%0d cycles=%0d required FETCH/1/9",
               dut_state, bus.insmem_addr, cycles);
    end
    for (int k = 2; k <= 5; k++) begin
      wait_state(ST_WAIT, 10, ok);
      checks++;
      if (!ok || exec_seen - base != k) begin
        failures++;
        $display("FAIL step_one_exec_per_pulse: got ok=%b execs=%0d required 1/%0d", ok, exec_seen - base, k);
      end
      step = 1'b1;
      @(negedge clk) step = 1'b0;
      checks++;
      if (dut_state !== ST_FETCH || bus.insmem_addr !== 11'(k)) begin
        failures++;
        $display("FAIL step_release: got state=%0d pc=%0d required FETCH/%0d", dut_state, bus.insmem_addr, k);
      end
    end
    wait_state(ST_WAIT, 10, ok);
    step_mode = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || dut_state !== ST_FETCH || bus.insmem_addr !== 11'd6) begin
      failures++;
      $display("FAIL step_mode_drop: got ok=%b state=%0d pc=%0d required 1/FETCH/6", ok, dut_state, bus.insmem_addr);
    end
    wait_state(ST_HALT, 50, ok);
    checks++;
    if (!ok || bus.insmem_addr !== 11'd9 || exp_q.size() != 0 || exec_seen - base != 10) begin
      failures++;
      $display("FAIL step_halt: got ok=%b pc=%0d left=%0d execs=%0d required 1/9/0/10",
               ok, bus.insmem_addr, exp_q.size(), exec_seen - base);
    end
  endtask

  task automatic test_nop_opcode();
    bit ok;
    mem[0] = mk(5'd31, 11'h5A5);
    mem[1] = mk(5'd0, 11'd0);
    push_expected(2);
    pulse_start();
    wait_state(ST_HALT, 20, ok);
    checks++;
    if (!ok || bus.insmem_addr !== 11'd1 || cycles !== 32'd4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL nop_then_halt: got ok=%b pc=%0d cycles=%0d left=%0d required 1/1/4/0",
               ok, bus.insmem_addr, cycles, exp_q.size());
    end
  endtask

  task automatic test_pc_wrap();
    bit ok;
    for (int i = 0; i < 2048; i++) mem[i] = mk(5'd3, 11'($urandom_range(0, 2047)));
    push_expected(2048);
    push_expected(4);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    sb_en = 1'b0;
    checks++;
    if (!ok || halt !== 1'b0) begin
      failures++;
      $display("FAIL pc_wrap: got drained=%b halt=%b left=%0d required 1/0/0", ok, halt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    mem[0] = mk(5'd3, 11'd5);
    mem[1] = mk(5'd4, 11'd3);
    mem[2] = mk(5'd0, 11'd0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sb_en = 1'b1;
    push_expected(2);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dut_state == ST_EXEC && bus.insmem_addr == 11'd1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || bus.wr_acc !== 1'b1 || bus.rd_ram !== 1'b1) begin
      failures++;
      $display("FAIL rst_add_strobes: got ok=%b wr_acc=%b rd_ram=%b required 1/1/1", ok, bus.wr_acc, bus.rd_ram);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_acc !== 1'b0 || bus.rd_ram !== 1'b0 || dut_state !== ST_IDLE ||
        bus.insmem_addr !== 11'd0 || cycles !== 32'd0) begin
      failures++;
      $display("FAIL rst_async_drop: got wr_acc=%b rd_ram=%b state=%0d pc=%0d cycles=%0d required 0/0/IDLE/0/0",
               bus.wr_acc, bus.rd_ram, dut_state, bus.insmem_addr, cycles);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_state !== ST_IDLE || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_stays_idle: got state=%0d left=%0d required IDLE/0", dut_state, exp_q.size());
    end
    push_expected(3);
    pulse_start();
    wait_state(ST_HALT, 20, ok);
    checks++;
    if (!ok || bus.insmem_addr !== 11'd2 || cycles !== 32'd6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_restart: got ok=%b pc=%0d cycles=%0d left=%0d required 1/2/6/0",
               ok, bus.insmem_addr, cycles, exp_q.size());
    end
  endtask

  task automatic test_restart_from_halt();
    bit ok;
    push_expected(3);
    @(negedge clk) start = 1'b1;
    checks++;
    if (halt !== 1'b1) begin
      failures++;
      $display("FAIL halt_before_start: got halt=%b required 1", halt);
    end
    @(negedge clk) start = 1'b0;
    checks++;
    if (halt !== 1'b0 || cycles !== 32'd0 || bus.insmem_addr !== 11'd0 || bus.insmem_enable !== 1'b1) begin
      failures++;
      $display("FAIL halt_restart_fetch: got halt=%b cycles=%0d pc=%0d en=%b required 0/0/0/1",
               halt, cycles, bus.insmem_addr, bus.insmem_enable);
    end
    wait_state(ST_HALT, 20, ok);
    checks++;
    if (!ok || cycles !== 32'd6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL halt_restart_done: got ok=%b cycles=%0d left=%0d required 1/6/0", ok, cycles, exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_run_program();
    test_step_mode();
    test_nop_opcode();
    test_pc_wrap();
    test_reset_mid_exec();
    test_restart_from_halt();
    sb_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Instruction sequencer for the BIP processor: owns the program counter, drives the address and read-enable of `bip_program_memory`, decodes each 16-bit instruction (5-bit opcode, 11-bit operand) and issues one cycle of datapath/data-memory control per instruction. It sits between the program memory and the accumulator datapath. It also supports run/step execution, halt detection and a cycle counter for the debug unit.

## Interface
- `NB_DATA`, 16: instruction width.
- `NB_OPCODE`, 5: opcode field width (bits 15:11).
- `LOG2_N_INSMEM_ADDR`, 11: program counter / operand width.
- `NB_CYCLES`, 32: cycle counter width.

- `i_clock`  in  1  single clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle pulse; starts execution from IDLE or HALT.
- `i_step_mode`  in  1  1 = pause after each instruction.
- `i_step`  in  1  one-cycle pulse; releases one instruction in step mode.
- `i_instruction`  in  NB_DATA  program memory `o_data`.
- `o_insmem_addr`  out  LOG2_N_INSMEM_ADDR  program memory `i_addr` (= PC).
- `o_insmem_enable`  out  1  program memory `i_enable`.
- `o_operand`  out  LOG2_N_INSMEM_ADDR  operand field; data address or immediate.
- `o_sel_a`  out  2  accumulator source: 0 data mem, 1 immediate, 2 ALU.
- `o_sel_b`  out  1  ALU operand B: 0 data mem, 1 immediate.
- `o_op_sub`  out  1  ALU op: 0 add, 1 subtract.
- `o_wr_acc`  out  1  accumulator write strobe.
- `o_wr_ram`  out  1  data memory write strobe.
- `o_rd_ram`  out  1  data memory read enable.
- `o_halt`  out  1  1 while in HALT.
- `o_cycles`  out  NB_CYCLES  cycles spent in FETCH/EXEC/WAIT since last start.

## Operation
- States: IDLE, FETCH, EXEC, WAIT, HALT. Reset → IDLE, PC=0, `o_cycles`=0, all outputs 0.
- IDLE: `i_start` → FETCH, PC=0, `o_cycles`=0.
- FETCH: `o_insmem_enable`=1, `o_insmem_addr`=PC. Always → EXEC.
- EXEC: `i_instruction` is valid; decode, assert control strobes this cycle only.
  - Opcode 0 (HLT) → HALT; PC not incremented.
  - Otherwise PC←PC+1 (11-bit, 2047 wraps to 0); → WAIT if `i_step_mode`, else FETCH.
- Decode (all other strobes 0): STO(1) `wr_ram`; LD(2) `rd_ram`,`sel_a`=0,`wr_acc`; LDI(3) `sel_a`=1,`wr_acc`; ADD(4) `rd_ram`,`sel_a`=2,`sel_b`=0,`wr_acc`; ADDI(5) `sel_a`=2,`sel_b`=1,`wr_acc`; SUB(6) as ADD + `op_sub`; SUBI(7) as ADDI + `op_sub`. Opcodes 8–31: NOP, PC advances.
- WAIT: `i_step` → FETCH; `i_step_mode` deasserted → FETCH.
- HALT: `o_halt`=1; `i_start` → FETCH with PC=0, `o_cycles`=0.
- `o_operand` = `i_instruction[10:0]` in EXEC, 0 otherwise.
- `o_cycles` increments once per cycle in FETCH, EXEC and WAIT; saturates at all-ones.
- `i_start` ignored in FETCH/EXEC/WAIT; `i_step` ignored outside WAIT.

## Timing
- 2 cycles per instruction in run mode (FETCH, EXEC); program memory read latency is exactly 1 cycle.
- Control strobes are Moore/decoded outputs, valid in EXEC only. The datapath and data memory capture on the clock edge ending EXEC.
- Start-to-first-strobe: `i_start` at edge N → FETCH in cycle N+1 → EXEC in cycle N+2.
- `i_start` and `i_step` in the same cycle in WAIT: `i_step` wins. `i_start` has no effect in WAIT.
- Reset asserted mid-instruction: all outputs 0 immediately (asynchronous). Execution resumes only on a new `i_start` after release.

## Structure
- Shared package `bip_pkg`: opcode localparams (HLT…SUBI), `sel_a` encodings, state encoding, field widths.
- One sub-module: `bip_instruction_decoder` (combinational opcode → strobe bundle). FSM, PC and cycle counter stay in `bip_control_unit`.

## Test plan
- Standard program (LD 1, ADDI 2, STO 7, LDI 8, SUB 2, ADD 2, STO 11, LDI 3, SUBI 3, HLT) in run mode → strobes match decode table per EXEC; HALT entered, `o_halt`=1, PC=9, `o_cycles`=20.
- Step mode, same program: no FETCH until each `i_step`; exactly one EXEC per pulse; held in WAIT 5 idle cycles → `o_cycles` counts WAIT cycles.
- Opcode 5'b11111 at addr 0, HLT at addr 1 → no strobes in first EXEC, PC=1, then HALT.
- Memory filled with LDI (no HLT) → PC wraps 2047→0, execution continues.
- Reset pulled low during EXEC of ADD → `o_wr_acc`/`o_rd_ram` drop same cycle; state IDLE; `i_start` after release restarts at PC=0.
- In HALT, `i_start` pulse → refetch from addr 0, `o_cycles` cleared, `o_halt` drops the following cycle.
